// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-stage types and constants
package core_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = 32'h0;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO with flush and occupancy count
// Head reads as zero when empty; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assert property (@(posedge CLK) disable iff (RSTN)
    !(push && !flush && !do_pop && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, RCH1 read issue, prefetch FIFO, redirect drain
// Optional misaligned-redirect fault and HALT state under `FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            CORE_STALL,
  output logic            RCH1_REQ,
  output logic [XLEN-1:0] RCH1_ADDR,
  input  logic            RCH1_ACK,
  input  logic            RCH1_RVALID,
  input  logic [XLEN-1:0] RCH1_DATA,
  input  logic            REDIRECT_VALID,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            FETCH_VALID,
  output logic [XLEN-1:0] FETCH_INSTR,
  output logic [XLEN-1:0] FETCH_PC,
  input  logic            DECODE_STALL,
  output logic            FETCH_FAULT
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   out_next;
  logic [CW-1:0]   df_count;
  logic [CW-1:0]   aq_count;
  logic            fault_pending;
  logic            accept;
  logic            rsp_push;
  logic            fault_push;
  logic            df_empty;
  logic            aq_empty;
  logic            misaligned;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] aq_head;
  logic [EW-1:0]   df_head;
  fetch_entry_t    push_e;
  fetch_entry_t    head_e;

  // Credit covers both buffered entries and reads still in flight.
  assign RCH1_REQ  = !RSTN && state == RUN && !CORE_STALL &&
                     (({1'b0, df_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign RCH1_ADDR = pc;
  assign accept    = RCH1_REQ && RCH1_ACK;
  assign out_next  = outstanding + CW'(accept) - CW'(RCH1_RVALID);
  assign rsp_push  = state == RUN && RCH1_RVALID && !REDIRECT_VALID;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |REDIRECT_PC[1:0];
  assign target     = REDIRECT_PC;
  assign fault_push = state == HALT && fault_pending && outstanding == '0 && !REDIRECT_VALID;
`else
  assign misaligned = 1'b0;
  assign target     = REDIRECT_PC & ~XLEN'(3);
  assign fault_push = 1'b0;
`endif

  always_comb begin
    push_e.pc    = aq_head;
    push_e.instr = RCH1_DATA;
    push_e.fault = 1'b0;
    if (fault_push) begin
      push_e.pc    = pc;
      push_e.instr = '0;
      push_e.fault = 1'b1;
    end
  end

  assign head_e      = df_head;
  assign FETCH_VALID = !df_empty;
  assign FETCH_PC    = head_e.pc;
  assign FETCH_INSTR = head_e.instr;
  assign FETCH_FAULT = head_e.fault;

  fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_data_fifo (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .flush     (REDIRECT_VALID),
    .push      (rsp_push || fault_push),
    .push_data (push_e),
    .pop       (FETCH_VALID && !DECODE_STALL),
    .head      (df_head),
    .empty     (df_empty),
    .count     (df_count)
  );

  // Addresses of reads in flight, so each response is tagged with its PC.
  fetch_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_addr_queue (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .flush     (REDIRECT_VALID),
    .push      (accept),
    .push_data (RCH1_ADDR),
    .pop       (RCH1_RVALID && state == RUN),
    .head      (aq_head),
    .empty     (aq_empty),
    .count     (aq_count)
  );

  always_ff @(posedge CLK or posedge RSTN) begin
    if (RSTN) begin
      state         <= RUN;
      pc            <= RESET_PC;
      outstanding   <= '0;
      fault_pending <= 1'b0;
    end else begin
      outstanding <= out_next;
      if (REDIRECT_VALID) begin
        pc            <= target;
        fault_pending <= misaligned;
        if (misaligned)           state <= HALT;
        else if (out_next != '0)  state <= DRAIN;
        else                      state <= RUN;
      end else begin
        if (accept) pc <= pc + XLEN'(INSTR_BYTES);
        if (fault_push) fault_pending <= 1'b0;
        if (state == DRAIN && out_next == '0) state <= RUN;
      end
    end
  end

  assert property (@(posedge CLK) disable iff (RSTN)
    (state == RUN) |-> (aq_count == outstanding && !(RCH1_RVALID && aq_empty)));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with in-order memory model
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        CORE_STALL = 1'b0;
  logic        RCH1_REQ;
  logic [31:0] RCH1_ADDR;
  logic        RCH1_ACK = 1'b0;
  logic        RCH1_RVALID = 1'b0;
  logic [31:0] RCH1_DATA = '0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        FETCH_VALID;
  logic [31:0] FETCH_INSTR;
  logic [31:0] FETCH_PC;
  logic        DECODE_STALL = 1'b0;
  logic        FETCH_FAULT;

  int n_tests = 0;
  int n_fail  = 0;

  // memory model: in-order responses, each with a due cycle
  logic [31:0] rq_addr[$];
  int          rq_due[$];
  int          last_due;
  int          cyc;
  int          lat_min = 1, lat_max = 1, ack_pct = 100;

  // scoreboard: expected issue and delivery streams
  logic [31:0] exp_issue, exp_fetch, halt_pc;
  bit          draining, halted, fault_seen, prev_redirect;
  int          acks, pops;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RSTN(RSTN), .CORE_STALL(CORE_STALL),
    .RCH1_REQ(RCH1_REQ), .RCH1_ADDR(RCH1_ADDR), .RCH1_ACK(RCH1_ACK),
    .RCH1_RVALID(RCH1_RVALID), .RCH1_DATA(RCH1_DATA),
    .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .FETCH_VALID(FETCH_VALID), .FETCH_INSTR(FETCH_INSTR), .FETCH_PC(FETCH_PC),
    .DECODE_STALL(DECODE_STALL), .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    CORE_STALL = 0; RCH1_ACK = 0; RCH1_RVALID = 0; REDIRECT_VALID = 0; DECODE_STALL = 0;
    rq_addr.delete(); rq_due.delete();
    @(negedge CLK);
    RSTN = 1'b0;
    last_due = -1; cyc = 0; acks = 0; pops = 0;
    exp_issue = 32'h0; exp_fetch = 32'h0;
    draining = 0; halted = 0; fault_seen = 0; prev_redirect = 0;
  endtask

  // One clock cycle: entered just after a negedge with stimulus already set.
  task automatic step();
    logic [31:0] tgt, e_pc, e_instr;
    logic        e_fault;
    int          due;
    if (draining && rq_addr.size() == 0) draining = 0;
    #1;
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      RCH1_RVALID = 1'b1;
      RCH1_DATA   = mem_word(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end else begin
      RCH1_RVALID = 1'b0;
      RCH1_DATA   = $urandom;
    end
    RCH1_ACK = ($urandom_range(99) < ack_pct);
    #1;
    if (prev_redirect) begin
      n_tests++;
      if (FETCH_VALID !== 1'b0) begin
        n_fail++; $display("FAIL flush_valid: got %b want 0 (cycle %0d)", FETCH_VALID, cyc);
      end
    end
    if (draining || halted) begin
      n_tests++;
      if (RCH1_REQ !== 1'b0) begin
        n_fail++; $display("FAIL drain_no_req: got %b want 0 (cycle %0d)", RCH1_REQ, cyc);
      end
    end
    if (RCH1_REQ === 1'b1) begin
      n_tests++;
      if (RCH1_ADDR !== exp_issue) begin
        n_fail++; $display("FAIL issue_addr: got %h want %h", RCH1_ADDR, exp_issue);
      end
      if (RCH1_ACK) begin
        rq_addr.push_back(RCH1_ADDR);
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rq_due.push_back(due);
        exp_issue = exp_issue + 32'd4;
        acks++;
        n_tests++;
        if (rq_addr.size() > DEPTH) begin
          n_fail++; $display("FAIL credit: got %0d outstanding want <= %0d", rq_addr.size(), DEPTH);
        end
      end
    end
    if (FETCH_VALID === 1'b1 && !DECODE_STALL && !REDIRECT_VALID) begin
      n_tests++;
      if (halted) begin
        e_pc = halt_pc; e_instr = 32'h0; e_fault = 1'b1;
      end else begin
        e_pc = exp_fetch; e_instr = mem_word(exp_fetch); e_fault = 1'b0;
      end
      if (halted && fault_seen) begin
        n_fail++; $display("FAIL extra_entry: got pc %h want no entry after fault", FETCH_PC);
      end else if ({FETCH_PC, FETCH_INSTR, FETCH_FAULT} !== {e_pc, e_instr, e_fault}) begin
        n_fail++;
        $display("FAIL fetch_entry: got pc %h instr %h fault %b want pc %h instr %h fault %b",
                 FETCH_PC, FETCH_INSTR, FETCH_FAULT, e_pc, e_instr, e_fault);
      end
      if (halted) fault_seen = 1;
      else exp_fetch = exp_fetch + 32'd4;
      pops++;
    end
    prev_redirect = REDIRECT_VALID;
    if (REDIRECT_VALID) begin
      tgt = REDIRECT_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        halted = 1; halt_pc = tgt; fault_seen = 0;
      end else begin
        halted = 0;
      end
`else
      tgt[1:0] = 2'b00;
`endif
      exp_issue = tgt;
      exp_fetch = tgt;
      draining  = (rq_addr.size() > 0);
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] t);
    REDIRECT_VALID = 1'b1;
    REDIRECT_PC    = t;
    step();
    REDIRECT_VALID = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (5) step();
    @(negedge CLK);
    RSTN = 1'b1;
    #1;
    n_tests++;
    if ({RCH1_REQ, RCH1_ADDR} !== {1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_req: got %b/%h want 0/00000000", RCH1_REQ, RCH1_ADDR);
    end
    n_tests++;
    if ({FETCH_VALID, FETCH_FAULT} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b%b want 00", FETCH_VALID, FETCH_FAULT);
    end
    n_tests++;
    if ({FETCH_INSTR, FETCH_PC} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h want 0 0", FETCH_INSTR, FETCH_PC);
    end
  endtask

  task automatic test_basic();
    int first = -1;
    do_reset();
    lat_min = 1; lat_max = 1; ack_pct = 100;
    for (int k = 0; k < 10; k++) begin
      if (FETCH_VALID === 1'b1 && first < 0) first = cyc;
      step();
      if (k == 5) begin
        n_tests++;
        if (pops != 4) begin
          n_fail++; $display("FAIL basic_stream: got %0d pops want 4", pops);
        end
      end
    end
    n_tests++;
    if (first != 2) begin
      n_fail++; $display("FAIL first_valid: got cycle %0d want 2", first);
    end
  endtask

  task automatic test_stall_credit();
    do_reset();
    lat_min = 1; lat_max = 1; ack_pct = 100;
    DECODE_STALL = 1'b1;
    repeat (10) step();
    #1;
    n_tests++;
    if (acks != DEPTH) begin
      n_fail++; $display("FAIL stall_acks: got %0d want %0d", acks, DEPTH);
    end
    n_tests++;
    if (RCH1_REQ !== 1'b0) begin
      n_fail++; $display("FAIL stall_req: got %b want 0", RCH1_REQ);
    end
    DECODE_STALL = 1'b0;
    repeat (12) step();
    n_tests++;
    if (pops < 5 || acks < 5) begin
      n_fail++; $display("FAIL stall_release: got %0d pops %0d acks want >=5 each", pops, acks);
    end
  endtask

  task automatic test_redirect_drain();
    int p0, bound;
    do_reset();
    lat_min = 4; lat_max = 4; ack_pct = 100;
    bound = 0;
    while (rq_addr.size() < 2 && bound < 20) begin step(); bound++; end
    CORE_STALL = 1'b1;
    redirect(32'h100);
    CORE_STALL = 1'b0;
    n_tests++;
    if (!draining) begin
      n_fail++; $display("FAIL drain_setup: got %0d outstanding want 2", rq_addr.size());
    end
    p0 = pops; bound = 0;
    while (pops == p0 && bound < 30) begin step(); bound++; end
    n_tests++;
    if (pops == p0) begin
      n_fail++; $display("FAIL drain_timeout: got no entry want pc 00000100");
    end
  endtask

  task automatic test_flush_full();
    int bound, p0;
    do_reset();
    lat_min = 1; lat_max = 1; ack_pct = 100;
    DECODE_STALL = 1'b1;
    repeat (8) step();
    DECODE_STALL = 1'b0;
    redirect(32'h300);
    repeat (8) step();
    do_reset();
    lat_min = 3; lat_max = 3;
    DECODE_STALL = 1'b1;
    bound = 0;
    while (!(acks == DEPTH && rq_addr.size() == 1 && rq_due[0] == cyc) && bound < 20) begin
      step(); bound++;
    end
    n_tests++;
    if (bound >= 20) begin
      n_fail++; $display("FAIL rvalid_setup: got timeout want rvalid with 3 buffered");
    end
    DECODE_STALL = 1'b0;
    p0 = pops;
    redirect(32'h340);
    repeat (12) step();
    n_tests++;
    if (pops == p0) begin
      n_fail++; $display("FAIL after_flush: got no entry want pc 00000340");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat_min = 1; lat_max = 1; ack_pct = 100;
    redirect(32'hFFFF_FFF8);
    repeat (10) step();
    n_tests++;
    if (!(exp_issue < 32'h40 && exp_fetch < 32'h40)) begin
      n_fail++; $display("FAIL wrap: got issue %h fetch %h want wrapped below 40", exp_issue, exp_fetch);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    lat_min = 2; lat_max = 2; ack_pct = 100;
    repeat (4) step();
    redirect(32'h102);
    repeat (15) step();
`ifdef FETCH_ALIGN_CHECK_EN
    n_tests++;
    if (!fault_seen) begin
      n_fail++; $display("FAIL fault_entry: got none want pc 00000102 fault 1");
    end
    redirect(32'h200);
    repeat (10) step();
    n_tests++;
    if (!(exp_fetch > 32'h200)) begin
      n_fail++; $display("FAIL resume: got next %h want > 00000200", exp_fetch);
    end
`else
    n_tests++;
    if (!(exp_fetch > 32'h100)) begin
      n_fail++; $display("FAIL forced_align: got next %h want > 00000100", exp_fetch);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] t;
    do_reset();
    lat_min = 1; lat_max = 3; ack_pct = 70;
    for (int k = 0; k < 2000; k++) begin
      CORE_STALL   = ($urandom_range(7) == 0);
      DECODE_STALL = ($urandom_range(3) == 0);
      if ($urandom_range(39) == 0) begin
        t = $urandom & 32'h0000_FFFC;
        if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3));
        redirect(t);
      end else begin
        step();
      end
    end
    CORE_STALL = 0; DECODE_STALL = 0;
    repeat (10) step();
    n_tests++;
    if (pops < 100) begin
      n_fail++; $display("FAIL random_progress: got %0d pops want >= 100", pops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_credit();
    test_redirect_drain();
    test_flush_full();
    test_wrap();
    test_misaligned();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
